// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo: small synchronous FIFO that decouples the instruction frontend
// from the instruction realigner.
//
// fetch_fifo_pkg holds the frontend_fetch_t entry type shared with the
// frontend, the realigner and the testbench.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_ni       asynchronous active-low reset (clears pointers and counter)
//   flush_i      discard every buffered entry; beats push and pop
//   in_entry_i   fetch entry from the frontend
//   in_valid_i   in_entry_i is valid
//   in_ready_o   FIFO accepts in_entry_i this cycle
//   out_entry_o  head entry (read straight from storage)
//   out_valid_o  out_entry_o is valid
//   out_ack_i    realigner consumed the head entry (pop)
//   usage_o      number of occupied entries
//   empty_o      usage_o == 0
//   full_o       usage_o == DEPTH
// -----------------------------------------------------------------------------
package fetch_fifo_pkg;
  typedef struct packed {
    logic [31:0] address;
    logic [31:0] instruction;
    logic        branch_predict;
    logic        bp_taken;
    logic        page_fault;
    logic [3:0]  id;
  } frontend_fetch_t;
endpackage

module fetch_fifo
  import fetch_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  frontend_fetch_t            in_entry_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output frontend_fetch_t            out_entry_o,
  output logic                       out_valid_o,
  input  logic                       out_ack_i,
  output logic [$clog2(DEPTH):0]     usage_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  frontend_fetch_t r_mem [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_count_nxt;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == {CW{1'b0}});

  // Flush masks both handshakes so a flushing cycle neither accepts nor
  // presents data. Full blocks writes even when a pop happens the same cycle.
  assign in_ready_o  = !w_full && !flush_i;
  assign out_valid_o = !w_empty && !flush_i;
  assign w_push      = in_valid_i && in_ready_o;
  assign w_pop       = out_ack_i && out_valid_o;

  assign out_entry_o = r_mem[r_rd_ptr];
  assign usage_o     = r_count;
  assign empty_o     = w_empty;
  assign full_o      = w_full;

  // Next occupancy: simultaneous push and pop leave it unchanged. Push is
  // gated by !full and pop by !empty, so the counter cannot leave 0..DEPTH.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointer and occupancy state; DEPTH is a power of two so pointers wrap
  // naturally from DEPTH-1 to 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= {PW{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else if (flush_i) begin
      r_rd_ptr <= {PW{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_entry_i;
    end
  end

endmodule

// File: tb/tb_fetch_fifo.sv
// -----------------------------------------------------------------------------
// tb_fetch_fifo: directed bench for fetch_fifo (DEPTH = 4). The stimulus
// process pushes every entry it expects the FIFO to accept into a scoreboard
// queue; a monitor process pops and compares on every handshake at the output.
// -----------------------------------------------------------------------------
module tb_fetch_fifo;
  import fetch_fifo_pkg::*;

  localparam int DEPTH = 4;

  logic            clk_i;
  logic            rst_ni;
  logic            flush_i;
  frontend_fetch_t in_entry_i;
  logic            in_valid_i;
  logic            in_ready_o;
  frontend_fetch_t out_entry_o;
  logic            out_valid_o;
  logic            out_ack_i;
  logic [2:0]      usage_o;
  logic            empty_o;
  logic            full_o;

  int n_checks = 0;
  int n_errors = 0;
  frontend_fetch_t sb_q[$];

  fetch_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .in_entry_i  (in_entry_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .out_entry_o (out_entry_o),
    .out_valid_o (out_valid_o),
    .out_ack_i   (out_ack_i),
    .usage_o     (usage_o),
    .empty_o     (empty_o),
    .full_o      (full_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Entry with every field derived from address and id so that field swaps
  // or truncation show up in the compare.
  function automatic frontend_fetch_t mk(input logic [31:0] a, input logic [3:0] id);
    frontend_fetch_t e;
    e.address        = a;
    e.instruction    = ~a ^ {28'h0000000, id};
    e.branch_predict = id[0];
    e.bp_taken       = id[1];
    e.page_fault     = id[2];
    e.id             = id;
    return e;
  endfunction

  task automatic chk(input string n, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // One clock of stimulus; inputs change 1 time unit after the edge and the
  // task returns 2 units after the edge so checks see settled outputs.
  task automatic cyc(input logic v, input frontend_fetch_t e, input logic a,
                     input logic f, input logic acc);
    @(posedge clk_i);
    #1;
    in_valid_i = v;
    in_entry_i = e;
    out_ack_i  = a;
    flush_i    = f;
    if (f) sb_q.delete();
    if (acc) sb_q.push_back(e);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every output handshake must match the oldest expected entry.
  always @(negedge clk_i) begin
    if (rst_ni && out_valid_o && out_ack_i) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL pop_unexpected: got addr %0h expected no entry", out_entry_o.address);
      end else begin
        if (out_entry_o !== sb_q[0]) begin
          n_errors++;
          $display("FAIL pop_order: got %0h expected %0h", out_entry_o, sb_q[0]);
        end
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    frontend_fetch_t e_b;
    rst_ni     = 1'b0;
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    in_entry_i = '0;
    out_ack_i  = 1'b0;
    #12;
    chk("rst_usage",  80'(usage_o),     80'd0);
    chk("rst_empty",  80'(empty_o),     80'd1);
    chk("rst_full",   80'(full_o),      80'd0);
    chk("rst_ready",  80'(in_ready_o),  80'd1);
    chk("rst_valid",  80'(out_valid_o), 80'd0);
    #6 rst_ni = 1'b1;

    // First push after reset, visible one cycle later.
    cyc(1'b1, mk(32'h8000_0000, 4'd1), 1'b0, 1'b0, 1'b1);
    chk("a_nobypass", 80'(out_valid_o), 80'd0);
    idle();
    chk("a_valid", 80'(out_valid_o), 80'd1);
    chk("a_entry", 80'(out_entry_o), 80'(mk(32'h8000_0000, 4'd1)));
    chk("a_usage", 80'(usage_o),     80'd1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("a_drained", 80'(empty_o), 80'd1);

    // Fill to DEPTH, then a rejected push, then push+pop while full.
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b1, mk(32'h0000_1000 + 32'(i * 4), 4'(i + 2)), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, mk(32'h0000_DEAD, 4'd15), 1'b0, 1'b0, 1'b0);
    chk("full_flag",  80'(full_o),     80'd1);
    chk("full_ready", 80'(in_ready_o), 80'd0);
    chk("full_usage", 80'(usage_o),    80'd4);
    cyc(1'b1, mk(32'h0000_BEEF, 4'd14), 1'b1, 1'b0, 1'b0);
    chk("full_pop_ready", 80'(in_ready_o), 80'd0);
    idle();
    chk("after_pop_ready", 80'(in_ready_o), 80'd1);
    chk("after_pop_usage", 80'(usage_o),    80'd3);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("fill_drained", 80'(usage_o), 80'd0);

    // Sustained push + ack across several pointer wraps.
    cyc(1'b1, mk(32'h0000_2000, 4'd0), 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 3 * DEPTH; i++) begin
      cyc(1'b1, mk(32'h0000_2000 + 32'(i * 4), 4'(i)), 1'b1, 1'b0, 1'b1);
      chk("stream_usage", 80'(usage_o), 80'd1);
    end
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("stream_drained", 80'(usage_o), 80'd0);

    // Head held while the realigner withholds ack; pushes still land.
    e_b = mk(32'h0000_3000, 4'd9);
    cyc(1'b1, e_b, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, mk(32'h0000_3100 + 32'(k * 4), 4'(k + 10)), 1'b0, 1'b0, 1'b1);
      chk("hold_entry", 80'(out_entry_o), 80'(e_b));
      chk("hold_usage", 80'(usage_o),     80'(k + 1));
    end
    idle();
    chk("hold_usage_end", 80'(usage_o),     80'd4);
    chk("hold_entry_end", 80'(out_entry_o), 80'(e_b));
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush at occupancy 3 with same-cycle push and ack.
    cyc(1'b1, mk(32'h0000_F1F1, 4'd7), 1'b1, 1'b1, 1'b0);
    chk("flush_ready", 80'(in_ready_o),  80'd0);
    chk("flush_valid", 80'(out_valid_o), 80'd0);
    idle();
    chk("flush_usage",  80'(usage_o),     80'd0);
    chk("flush_ovalid", 80'(out_valid_o), 80'd0);
    chk("flush_empty",  80'(empty_o),     80'd1);
    for (int k = 0; k < 3; k++)
      cyc(1'b1, mk(32'h0000_F200, 4'(k)), 1'b0, 1'b1, 1'b0);
    cyc(1'b1, mk(32'h0000_4000, 4'd5), 1'b0, 1'b0, 1'b1);
    chk("held_flush_usage", 80'(usage_o), 80'd0);
    idle();
    chk("postflush_valid", 80'(out_valid_o), 80'd1);
    chk("postflush_entry", 80'(out_entry_o), 80'(mk(32'h0000_4000, 4'd5)));
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-stream at occupancy 2.
    cyc(1'b1, mk(32'h0000_5000, 4'd3), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, mk(32'h0000_5004, 4'd4), 1'b0, 1'b0, 1'b1);
    idle();
    chk("pre_rst_usage", 80'(usage_o), 80'd2);
    rst_ni = 1'b0;
    sb_q.delete();
    #1;
    chk("arst_valid", 80'(out_valid_o), 80'd0);
    chk("arst_ready", 80'(in_ready_o),  80'd1);
    chk("arst_usage", 80'(usage_o),     80'd0);
    chk("arst_empty", 80'(empty_o),     80'd1);
    chk("arst_full",  80'(full_o),      80'd0);
    #10 rst_ni = 1'b1;
    cyc(1'b1, mk(32'h0000_C000, 4'd12), 1'b0, 1'b0, 1'b1);
    idle();
    chk("c_first", 80'(out_entry_o), 80'(mk(32'h0000_C000, 4'd12)));
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle();
    idle();
    chk("sb_empty", 80'(sb_q.size()), 80'd0);
    chk("end_empty", 80'(empty_o), 80'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_fifo.md
FETCH_FIFO -- requirements
Module: fetch_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of frontend_fetch_t entries buffered (power of two, >= 2).
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port flush_i  input  1  discard all buffered entries.
REQ-005 SHALL have port in_entry_i  input  frontend_fetch_t  fetch entry from the frontend.
REQ-006 SHALL have port in_valid_i  input  1  in_entry_i is valid.
REQ-007 SHALL have port in_ready_o  output  1  FIFO accepts in_entry_i this cycle.
REQ-008 SHALL have port out_entry_o  output  frontend_fetch_t  head entry, to the instruction realigner.
REQ-009 SHALL have port out_valid_o  output  1  out_entry_o is valid.
REQ-010 SHALL have port out_ack_i  input  1  realigner consumed the head entry (pop).
REQ-011 SHALL have port usage_o  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-012 SHALL have ports empty_o and full_o  output  1 each  usage_o == 0 and usage_o == DEPTH respectively.

Function
REQ-013 SHALL store entries in a DEPTH-entry register array with read pointer, write pointer (each $clog2(DEPTH) bits, wrap DEPTH-1 -> 0) and occupancy counter ($clog2(DEPTH)+1 bits).
REQ-014 SHALL drive in_ready_o = !full_o && !flush_i; no write when full, even with a same-cycle pop.
REQ-015 SHALL push in_entry_i at the write pointer and increment the write pointer when in_valid_i && in_ready_o.
REQ-016 SHALL drive out_valid_o = !empty_o && !flush_i and out_entry_o = array[read pointer], combinationally from storage; no input-to-output bypass (first-word latency one cycle).
REQ-017 SHALL pop (increment read pointer) when out_ack_i && out_valid_o; out_ack_i while out_valid_o = 0 SHALL be ignored.
REQ-018 SHALL hold out_entry_o stable while out_valid_o = 1 and out_ack_i = 0; the realigner holds ack low across multi-cycle consumption (e.g. second compressed half).
REQ-019 Occupancy: push only -> +1; pop only -> -1; push and pop same cycle -> unchanged, both pointers advance.
REQ-020 Counter SHALL never exceed DEPTH nor underflow below 0 under any input sequence.
REQ-021 flush_i = 1: pointers and counter cleared on next edge; same-cycle in_valid_i and out_ack_i ignored; array contents need not be cleared.
REQ-022 Flush priority SHALL exceed push and pop; flush held for several cycles keeps the FIFO empty.
REQ-023 After flush deasserts, the first accepted entry SHALL appear at out_entry_o one cycle later.
REQ-024 Entries SHALL exit in strict arrival order with all fields (address, instruction, branch_predict, bp_taken, page_fault, id) bit-exact.

Reset
REQ-025 On rst_ni = 0, SHALL clear pointers and counter asynchronously: out_valid_o = 0, in_ready_o = 1, usage_o = 0, empty_o = 1, full_o = 0.
REQ-026 Reset mid-operation SHALL discard all entries; array storage need not be reset.
REQ-027 After rst_ni rises, SHALL accept a push on the first clock edge.

Verification
REQ-028 Reset release, push A (address 0x80000000) cycle 0 -> out_valid_o = 1, out_entry_o = A in cycle 1, usage_o = 1.
REQ-029 DEPTH = 4, push 4 entries, no ack -> full_o = 1, in_ready_o = 0, 5th push ignored; pop one -> in_ready_o = 1 next cycle.
REQ-030 Sustained push + ack every cycle for 3*DEPTH entries -> usage_o constant, order preserved across pointer wrap, no loss.
REQ-031 Head B valid, out_ack_i low 3 cycles with pushes -> out_entry_o = B unchanged each cycle, usage_o increments per push.
REQ-032 Occupancy 3, flush_i with in_valid_i and out_ack_i same cycle -> next cycle usage_o = 0, out_valid_o = 0, pushed entry absent.
REQ-033 rst_ni low mid-stream at occupancy 2 -> outputs at reset values immediately (before next edge); post-reset push C -> C is first out.
